// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the key / reset conditioner.
// Optional feature macro: KEY_COND_EVENT_EN (press/release pulse generation).
package key_cond_pkg;

  typedef enum logic [1:0] {
    RST_ASSERT = 2'd0,
    RST_HOLD   = 2'd1,
    RUN        = 2'd2
  } rst_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd250000;
  localparam int unsigned DEFAULT_RST_HOLD_CYCLES = 32'd16;

  // Counter width for a count of n; keeps at least one bit for degenerate n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter, debounced
// level and optional press/release pulses (KEY_COND_EVENT_EN).
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          mismatch_s;
  logic          accept_s;

  // The counter only advances while the sample disagrees with the level, and
  // the level flips exactly when it has seen DEBOUNCE_CYCLES disagreeing samples.
  assign mismatch_s = sync2_r ^ level_r;
  assign accept_s   = mismatch_s & (cnt_r == CNT_LAST);

  // Bring the asynchronous button into the clock domain (idle = released = 1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive disagreeing samples and flip the level once stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= 1'b1;
      cnt_r   <= '0;
    end else if (!mismatch_s) begin
      cnt_r   <= '0;
    end else if (accept_s) begin
      level_r <= ~level_r;
      cnt_r   <= '0;
    end else begin
      cnt_r   <= cnt_r + 1'b1;
    end
  end

  assign key_level = level_r;

`ifdef KEY_COND_EVENT_EN
  logic press_r;
  logic release_r;

  // Single-cycle events aligned with the level change (old level tells direction).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      press_r   <= accept_s & level_r;
      release_r <= accept_s & ~level_r;
    end
  end

  assign key_press   = press_r;
  assign key_release = release_r;
`else
  assign key_press   = 1'b0;
  assign key_release = 1'b0;
`endif

endmodule

// File: rtl/key_reset_conditioner.sv
// Debounces NUM_KEYS push buttons and builds the system reset from key 0 and
// the JTAG reset request. Reset asserts asynchronously and releases
// synchronously after RST_HOLD_CYCLES quiet cycles.
// Optional feature macro: KEY_COND_EVENT_EN (press/release pulse outputs).
module key_reset_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 32'd2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned RST_HOLD_CYCLES = DEFAULT_RST_HOLD_CYCLES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw_i,
  input  logic                jtag_reset_i,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  output logic                sys_reset_n_o
);

  localparam int unsigned HW = cnt_width(RST_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 32'd1);

  rst_state_e    state_r;
  logic [HW-1:0] hold_cnt_r;
  logic          sys_reset_n_r;
  logic          jtag_sync1_r;
  logic          jtag_sync2_r;
  logic          src_active_s;

  genvar g;
  for (g = 0; g < NUM_KEYS; g = g + 1) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_raw    (key_raw_i[g]),
      .key_level  (key_level_o[g]),
      .key_press  (key_press_o[g]),
      .key_release(key_release_o[g])
    );
  end

  // Bring the asynchronous JTAG reset request into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_sync1_r <= 1'b0;
      jtag_sync2_r <= 1'b0;
    end else begin
      jtag_sync1_r <= jtag_reset_i;
      jtag_sync2_r <= jtag_sync1_r;
    end
  end

  // Key 0 held down (debounced) or JTAG request keeps the system in reset.
  assign src_active_s = ~key_level_o[0] | jtag_sync2_r;

  // Reset sequencer; the output register is updated alongside the state so it
  // always equals (state == RUN) without a combinational input path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= RST_ASSERT;
      hold_cnt_r    <= '0;
      sys_reset_n_r <= 1'b0;
    end else begin
      case (state_r)
        RST_ASSERT: begin
          hold_cnt_r    <= '0;
          sys_reset_n_r <= 1'b0;
          if (!src_active_s) begin
            state_r <= RST_HOLD;
          end else begin
            state_r <= RST_ASSERT;
          end
        end
        RST_HOLD: begin
          if (src_active_s) begin
            state_r       <= RST_ASSERT;
            hold_cnt_r    <= '0;
            sys_reset_n_r <= 1'b0;
          end else if (hold_cnt_r == HOLD_LAST) begin
            state_r       <= RUN;
            hold_cnt_r    <= '0;
            sys_reset_n_r <= 1'b1;
          end else begin
            hold_cnt_r    <= hold_cnt_r + 1'b1;
            sys_reset_n_r <= 1'b0;
          end
        end
        RUN: begin
          hold_cnt_r <= '0;
          if (src_active_s) begin
            state_r       <= RST_ASSERT;
            sys_reset_n_r <= 1'b0;
          end else begin
            sys_reset_n_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= RST_ASSERT;
          hold_cnt_r    <= '0;
          sys_reset_n_r <= 1'b0;
        end
      endcase
    end
  end

  assign sys_reset_n_o = sys_reset_n_r;

endmodule

// File: tb/tb_key_reset_conditioner.sv
// Randomised self-checking bench for key_reset_conditioner. The reference
// model keeps the raw sample history: a key level flips when the last
// DEBOUNCE_CYCLES synchronized samples all disagree with it (and all arrived
// after the previous flip); the system reset is released once the reset
// source has been quiet for RST_HOLD_CYCLES+1 consecutive edges.
module tb_key_reset_conditioner;

  localparam int NK   = 2;
  localparam int DEB  = 8;
  localparam int HOLD = 4;

`ifdef KEY_COND_EVENT_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_raw_i = 2'b11;
  logic          jtag_reset_i = 1'b0;
  logic [NK-1:0] key_level_o;
  logic [NK-1:0] key_press_o;
  logic [NK-1:0] key_release_o;
  logic          sys_reset_n_o;

  key_reset_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .RST_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_raw_i(key_raw_i),
    .jtag_reset_i(jtag_reset_i), .key_level_o(key_level_o),
    .key_press_o(key_press_o), .key_release_o(key_release_o),
    .sys_reset_n_o(sys_reset_n_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [NK-1:0] khist[$];
  logic          jhist[$];
  int            k;
  int            m_last[NK];
  logic [NK-1:0] m_lvl, m_press, m_rel;
  int            m_run;
  logic          m_sys;

  task automatic model_reset();
    khist.delete(); jhist.delete();
    khist.push_back(2'b11); khist.push_back(2'b11);
    jhist.push_back(1'b0);  jhist.push_back(1'b0);
    k = 0; m_lvl = 2'b11; m_press = 2'b00; m_rel = 2'b00;
    m_run = 0; m_sys = 1'b0;
    for (int i = 0; i < NK; i++) m_last[i] = -1;
  endtask

  // Advance one clock edge in both DUT and model; returns at the next negedge.
  task automatic step();
    logic src, ok;
    logic [NK-1:0] h, np, nr;
    int start;
    @(posedge clk);
    khist.push_back(key_raw_i);
    jhist.push_back(jtag_reset_i);
    src = ~m_lvl[0] | jhist[k];
    np = '0; nr = '0;
    for (int i = 0; i < NK; i++) begin
      start = k - DEB + 1;
      ok = (start >= 0) && (start > m_last[i]);
      if (ok) begin
        for (int j = start; j <= k; j++) begin
          h = khist[j];
          if (h[i] == m_lvl[i]) ok = 1'b0;
        end
      end
      if (ok) begin
        np[i] = m_lvl[i];
        nr[i] = ~m_lvl[i];
        m_lvl[i] = ~m_lvl[i];
        m_last[i] = k;
      end
    end
    m_press = EV ? np : 2'b00;
    m_rel   = EV ? nr : 2'b00;
    m_run   = src ? 0 : m_run + 1;
    m_sys   = (m_run >= HOLD + 1);
    k++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({key_level_o, key_press_o, key_release_o, sys_reset_n_o} !== 7'b11_00_00_0)
      $display("FAIL reset_state: got lvl=%b p=%b r=%b sys=%b want lvl=11 p=00 r=00 sys=0",
               key_level_o, key_press_o, key_release_o, sys_reset_n_o);
    else passed++;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int rise = 0;
    key_raw_i = 2'b11; jtag_reset_i = 1'b0;
    @(negedge clk);
    apply_reset();
    for (int n = 1; n <= 10; n++) begin
      step();
      checks++;
      if ({key_level_o, key_press_o, key_release_o, sys_reset_n_o} !== {m_lvl, m_press, m_rel, m_sys})
        $display("FAIL reset_seq n=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", n, key_level_o,
                 key_press_o, key_release_o, sys_reset_n_o, m_lvl, m_press, m_rel, m_sys);
      else passed++;
      if (sys_reset_n_o === 1'b1 && rise == 0) rise = n;
    end
    checks++;
    if (rise !== HOLD + 1) $display("FAIL reset_release_latency: got %0d want %0d", rise, HOLD + 1);
    else passed++;
  endtask

  task automatic test_glitch();
    logic moved = 1'b0;
    key_raw_i[1] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (n == 5) key_raw_i[1] = 1'b1;
      step();
      if (key_level_o[1] !== 1'b1 || key_press_o[1] !== 1'b0 || key_release_o[1] !== 1'b0) moved = 1'b1;
      checks++;
      if ({key_level_o, key_press_o, key_release_o, sys_reset_n_o} !== {m_lvl, m_press, m_rel, m_sys})
        $display("FAIL glitch n=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", n, key_level_o,
                 key_press_o, key_release_o, sys_reset_n_o, m_lvl, m_press, m_rel, m_sys);
      else passed++;
    end
    checks++;
    if (moved !== 1'b0) $display("FAIL glitch_ignored: got moved=%b want 0", moved);
    else passed++;
  endtask

  task automatic test_press_release();
    int fall = 0, rise = 0, np = 0, nr = 0;
    key_raw_i[1] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (key_level_o[1] === 1'b0 && fall == 0) fall = n;
      if (key_press_o[1] === 1'b1) np++;
      checks++;
      if ({key_level_o, key_press_o, key_release_o, sys_reset_n_o} !== {m_lvl, m_press, m_rel, m_sys})
        $display("FAIL press n=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", n, key_level_o,
                 key_press_o, key_release_o, sys_reset_n_o, m_lvl, m_press, m_rel, m_sys);
      else passed++;
    end
    key_raw_i[1] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (key_level_o[1] === 1'b1 && rise == 0) rise = n;
      if (key_release_o[1] === 1'b1) nr++;
      checks++;
      if ({key_level_o, key_press_o, key_release_o, sys_reset_n_o} !== {m_lvl, m_press, m_rel, m_sys})
        $display("FAIL release n=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", n, key_level_o,
                 key_press_o, key_release_o, sys_reset_n_o, m_lvl, m_press, m_rel, m_sys);
      else passed++;
    end
    checks++;
    if (fall !== DEB + 2 || rise !== DEB + 2)
      $display("FAIL debounce_latency: got fall=%0d rise=%0d want %0d", fall, rise, DEB + 2);
    else passed++;
    checks++;
    if (np !== (EV ? 1 : 0) || nr !== (EV ? 1 : 0))
      $display("FAIL pulse_count: got press=%0d release=%0d want %0d", np, nr, EV ? 1 : 0);
    else passed++;
  endtask

  task automatic test_jtag();
    int low = 0;
    jtag_reset_i = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      step();
      jtag_reset_i = 1'b0;
      if (sys_reset_n_o === 1'b0 && low == 0) low = n;
      checks++;
      if ({key_level_o, key_press_o, key_release_o, sys_reset_n_o} !== {m_lvl, m_press, m_rel, m_sys})
        $display("FAIL jtag n=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", n, key_level_o,
                 key_press_o, key_release_o, sys_reset_n_o, m_lvl, m_press, m_rel, m_sys);
      else passed++;
    end
    checks++;
    if (low !== 3) $display("FAIL jtag_assert_latency: got %0d want 3", low);
    else passed++;
  endtask

  task automatic test_hold_abort();
    // JTAG holds reset while key 0 debounces; key 0 lands two counts into hold.
    jtag_reset_i = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (n == 4) key_raw_i[0] = 1'b0;
      if (n == 9) jtag_reset_i = 1'b0;
      if (n == 22) key_raw_i[0] = 1'b1;
      step();
      checks++;
      if ({key_level_o, key_press_o, key_release_o, sys_reset_n_o} !== {m_lvl, m_press, m_rel, m_sys})
        $display("FAIL hold_abort n=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", n, key_level_o,
                 key_press_o, key_release_o, sys_reset_n_o, m_lvl, m_press, m_rel, m_sys);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 5) == 0) key_raw_i[i] = ~key_raw_i[i];
      jtag_reset_i = ($urandom_range(0, 39) == 0);
      if (n == 250) apply_reset();
      step();
      checks++;
      if ({key_level_o, key_press_o, key_release_o, sys_reset_n_o} !== {m_lvl, m_press, m_rel, m_sys})
        $display("FAIL random n=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", n, key_level_o,
                 key_press_o, key_release_o, sys_reset_n_o, m_lvl, m_press, m_rel, m_sys);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_press_release();
    test_jtag();
    test_hold_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, checks);
    $fatal(1);
  end

endmodule
